// File: rtl/p2s_framer_pkg.sv
// Shared constants and state encoding for the parallel-to-serial framer and
// the serial receive stage it feeds.
package p2s_framer_pkg;

  localparam int unsigned P2S_WIDTH = 16;
  localparam int unsigned P2S_LEN_W = 4;
  localparam int unsigned P2S_GAP   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

endpackage

// File: rtl/p2s_framer.sv
// Parallel-to-serial framer: loads one word per accepted start, shifts its low
// len bits out MSB-first with frame_en bracketing them, then idles GAP cycles.
module p2s_framer
  import p2s_framer_pkg::*;
#(
  parameter int unsigned WIDTH = P2S_WIDTH,
  parameter int unsigned LEN_W = P2S_LEN_W,
  parameter int unsigned GAP   = P2S_GAP
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len,
  input  logic             start,
  input  logic             abort,
  output logic             ready,
  output logic             serial_out,
  output logic             frame_en,
  output logic             done
);

  localparam int unsigned CNT_W = LEN_W + 1;
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [CNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [GAP_W-1:0]   gapcnt_q, gapcnt_d;
  logic               ser_q, ser_d;
  logic               fen_q, fen_d;
  logic               done_q, done_d;

  logic [CNT_W-1:0]   len_n;
  logic [CNT_W-1:0]   shamt;
  logic [WIDTH-1:0]   load_word;

  // len==0 encodes a full-width frame; MSB-align the frame so bit N-1 sits on top.
  always_comb begin
    len_n     = (len == '0) ? CNT_W'(WIDTH) : {1'b0, len};
    shamt     = CNT_W'(WIDTH) - len_n;
    load_word = data_in << shamt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      sreg_q   <= '0;
      bitcnt_q <= '0;
      gapcnt_q <= '0;
      ser_q    <= 1'b0;
      fen_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sreg_q   <= sreg_d;
      bitcnt_q <= bitcnt_d;
      gapcnt_q <= gapcnt_d;
      ser_q    <= ser_d;
      fen_q    <= fen_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sreg_d   = sreg_q;
    bitcnt_d = bitcnt_q;
    gapcnt_d = gapcnt_q;
    ser_d    = 1'b0;
    fen_d    = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sreg_d   = load_word;
          bitcnt_d = len_n;
          ser_d    = load_word[WIDTH-1];
          fen_d    = 1'b1;
          state_d  = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // abort takes priority over a normal end of frame and suppresses done
        if (abort) begin
          gapcnt_d = '0;
          state_d  = (GAP == 0) ? ST_IDLE : ST_GAP;
        end else if (bitcnt_q == CNT_W'(1)) begin
          done_d   = 1'b1;
          gapcnt_d = '0;
          state_d  = (GAP == 0) ? ST_IDLE : ST_GAP;
        end else begin
          sreg_d   = sreg_q << 1;
          ser_d    = sreg_q[WIDTH-2];
          fen_d    = 1'b1;
          bitcnt_d = bitcnt_q - CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (gapcnt_q == GAP_W'(GAP - 1)) begin
          gapcnt_d = '0;
          state_d  = ST_IDLE;
        end else begin
          gapcnt_d = gapcnt_q + GAP_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign ready      = (state_q == ST_IDLE);
  assign serial_out = ser_q;
  assign frame_en   = fen_q;
  assign done       = done_q;

endmodule
